// File: rtl/idli_pkg.sv
// rtl/idli_pkg.sv - shared idli types and constants for the SQI memory sequencer
package idli_pkg;

  localparam int SQI_NUM    = 2;
  localparam int SQI_MEM_LO = 0;
  localparam int SQI_MEM_HI = 1;

  typedef logic [3:0] sqi_data_t;
  typedef sqi_data_t [SQI_NUM-1:0] sqi_bus_t;
  typedef logic [7:0] sqi_cmd_t;

  localparam sqi_cmd_t SQI_CMD_READ  = 8'h03;
  localparam sqi_cmd_t SQI_CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    HOLD
  } sqi_state_t;

  function automatic sqi_cmd_t sqi_cmd(input logic wr);
    return wr ? SQI_CMD_WRITE : SQI_CMD_READ;
  endfunction

  // One SQI cycle moves a byte: high nibble on the HI memory, low nibble on LO.
  function automatic sqi_bus_t sqi_byte(input logic [7:0] b);
    sqi_bus_t bus;
    bus[SQI_MEM_HI] = b[7:4];
    bus[SQI_MEM_LO] = b[3:0];
    return bus;
  endfunction

endpackage

// File: rtl/idli_sqi_ctrl.sv
// rtl/idli_sqi_ctrl.sv - 16-bit word sequencer for paired SQI memories; IDLI_SQI_BURST_EN adds HOLD bursts
module idli_sqi_ctrl
  import idli_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_vld,
  output logic        o_req_rdy,
  input  logic        i_req_wr,
  input  logic [15:0] i_req_addr,
  input  logic [15:0] i_req_data,
  output logic        o_rsp_vld,
  output logic [15:0] o_rsp_data,
  output logic        o_sqi_cs_n,
  output logic        o_sqi_sck_en,
  output logic        o_sqi_oe,
  output sqi_bus_t    o_sqi_dout,
  input  sqi_bus_t    i_sqi_din
);

  sqi_state_t  state;
  logic [2:0]  cnt;
  logic [23:0] addr_sr;
  logic        wr_q;
  logic [15:0] data_q;
  logic [7:0]  rd_lo;

  logic        acc;
  logic        go;
  logic        start_wr;
  logic [15:0] start_addr;

`ifdef IDLI_SQI_BURST_EN
  logic        pend;
  logic [15:0] addr_q;
  logic        hit;

  assign hit = (i_req_wr == wr_q) && (addr_q != 16'hFFFF) && (i_req_addr == addr_q + 16'd1);
`endif

  assign acc = i_req_vld && o_req_rdy;

  // A burst miss parks the request for one deselected cycle, then starts from the latched copy.
  always_comb begin
    go         = acc;
    start_wr   = i_req_wr;
    start_addr = i_req_addr;
`ifdef IDLI_SQI_BURST_EN
    if (pend) begin
      go         = 1'b1;
      start_wr   = wr_q;
      start_addr = addr_q;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      addr_sr      <= 24'd0;
      wr_q         <= 1'b0;
      data_q       <= 16'd0;
      rd_lo        <= 8'd0;
      o_req_rdy    <= 1'b0;
      o_rsp_vld    <= 1'b0;
      o_rsp_data   <= 16'd0;
      o_sqi_cs_n   <= 1'b1;
      o_sqi_sck_en <= 1'b0;
      o_sqi_oe     <= 1'b0;
      o_sqi_dout   <= '0;
`ifdef IDLI_SQI_BURST_EN
      pend         <= 1'b0;
      addr_q       <= 16'd0;
`endif
    end else begin
      o_rsp_vld <= 1'b0;
      if (acc) begin
        wr_q   <= i_req_wr;
        data_q <= i_req_data;
`ifdef IDLI_SQI_BURST_EN
        addr_q <= i_req_addr;
`endif
      end

      case (state)
        IDLE: begin
          o_req_rdy    <= 1'b1;
          o_sqi_cs_n   <= 1'b1;
          o_sqi_sck_en <= 1'b0;
          o_sqi_oe     <= 1'b0;
          o_sqi_dout   <= '0;
          if (go) begin
            state        <= CMD;
            cnt          <= 3'd0;
            o_req_rdy    <= 1'b0;
            o_sqi_cs_n   <= 1'b0;
            o_sqi_sck_en <= 1'b1;
            o_sqi_oe     <= 1'b1;
            o_sqi_dout   <= sqi_byte(sqi_cmd(start_wr));
            addr_sr      <= {7'b0, start_addr, 1'b0};
`ifdef IDLI_SQI_BURST_EN
            pend         <= 1'b0;
`endif
          end
        end

        CMD: begin
          if (cnt == 3'd1) begin
            state      <= ADDR;
            cnt        <= 3'd0;
            o_sqi_dout <= sqi_byte({2{addr_sr[23:20]}});
            addr_sr    <= addr_sr << 4;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end

        // Each memory gets the full byte address, most significant nibble first.
        ADDR: begin
          if (cnt == 3'd5) begin
            cnt <= 3'd0;
            if (wr_q) begin
              state      <= DATA;
              o_sqi_dout <= sqi_byte(data_q[7:0]);
            end else begin
              state      <= DUMMY;
              o_sqi_oe   <= 1'b0;
              o_sqi_dout <= '0;
            end
          end else begin
            cnt        <= cnt + 3'd1;
            o_sqi_dout <= sqi_byte({2{addr_sr[23:20]}});
            addr_sr    <= addr_sr << 4;
          end
        end

        DUMMY: begin
          if (cnt == 3'd1) begin
            state <= DATA;
            cnt   <= 3'd0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end

        DATA: begin
          if (cnt == 3'd0) begin
            cnt <= 3'd1;
            if (wr_q) o_sqi_dout <= sqi_byte(data_q[15:8]);
            else      rd_lo      <= {i_sqi_din[SQI_MEM_HI], i_sqi_din[SQI_MEM_LO]};
          end else begin
            cnt          <= 3'd0;
            o_req_rdy    <= 1'b1;
            o_sqi_sck_en <= 1'b0;
            o_sqi_oe     <= 1'b0;
            o_sqi_dout   <= '0;
            if (!wr_q) begin
              o_rsp_vld  <= 1'b1;
              o_rsp_data <= {i_sqi_din[SQI_MEM_HI], i_sqi_din[SQI_MEM_LO], rd_lo};
            end
`ifdef IDLI_SQI_BURST_EN
            state        <= HOLD;
`else
            state        <= IDLE;
            o_sqi_cs_n   <= 1'b1;
`endif
          end
        end

`ifdef IDLI_SQI_BURST_EN
        // Chip stays selected with the clock stopped until the next request.
        HOLD: begin
          if (acc) begin
            o_req_rdy <= 1'b0;
            if (hit) begin
              state        <= DATA;
              cnt          <= 3'd0;
              o_sqi_sck_en <= 1'b1;
              o_sqi_oe     <= i_req_wr;
              o_sqi_dout   <= i_req_wr ? sqi_byte(i_req_data[7:0]) : '0;
            end else begin
              state      <= IDLE;
              pend       <= 1'b1;
              o_sqi_cs_n <= 1'b1;
            end
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idli_sqi_ctrl.sv
// tb/tb_idli_sqi_ctrl.sv - scoreboard bench for idli_sqi_ctrl (bus trace and read responses)
module tb_idli_sqi_ctrl;

`ifdef IDLI_SQI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_req_vld;
  logic        o_req_rdy;
  logic        i_req_wr;
  logic [15:0] i_req_addr;
  logic [15:0] i_req_data;
  logic        o_rsp_vld;
  logic [15:0] o_rsp_data;
  logic        o_sqi_cs_n;
  logic        o_sqi_sck_en;
  logic        o_sqi_oe;
  logic [7:0]  o_sqi_dout;
  logic [7:0]  i_sqi_din;

  always #5 i_clk = ~i_clk;

  idli_sqi_ctrl dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_vld    (i_req_vld),
    .o_req_rdy    (o_req_rdy),
    .i_req_wr     (i_req_wr),
    .i_req_addr   (i_req_addr),
    .i_req_data   (i_req_data),
    .o_rsp_vld    (o_rsp_vld),
    .o_rsp_data   (o_rsp_data),
    .o_sqi_cs_n   (o_sqi_cs_n),
    .o_sqi_sck_en (o_sqi_sck_en),
    .o_sqi_oe     (o_sqi_oe),
    .o_sqi_dout   (o_sqi_dout),
    .i_sqi_din    (i_sqi_din)
  );

  typedef struct {
    int         cyc;
    logic       cs_n;
    logic       sck;
    logic       oe;
    logic       rdy;
    bit         chk_dout;
    logic [7:0] dout;
    logic [7:0] din;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } rsp_t;

  exp_t        bq[$];
  rsp_t        rq[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          in_hold = 1'b0;
  bit          last_wr = 1'b0;
  logic [15:0] last_addr = 16'h0000;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic push_bus(input int lim, input int c, input logic cs_n, input logic sck,
                          input logic oe, input logic rdy, input bit chkd,
                          input logic [7:0] dout, input logic [7:0] din);
    exp_t e;
    if (c <= lim) begin
      e.cyc = c; e.cs_n = cs_n; e.sck = sck; e.oe = oe; e.rdy = rdy;
      e.chk_dout = chkd; e.dout = dout; e.din = din;
      bq.push_back(e);
    end
  endtask

  // Drive one request, wait for acceptance, and queue the expected pin trace and response.
  task automatic issue(input bit wr, input logic [15:0] addr, input logic [15:0] data,
                       input logic [15:0] rd, input int upto, output int t);
    logic [23:0] baddr;
    logic [3:0]  nib;
    int          k;
    int          n;
    int          lim;
    bit          hit;
    rsp_t        r;
    i_req_vld  = 1'b1;
    i_req_wr   = wr;
    i_req_addr = addr;
    i_req_data = data;
    n = 0;
    while (o_req_rdy !== 1'b1 && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 200) chk("req_rdy_timeout", 32'(o_req_rdy), 32'd1);
    t     = cyc;
    lim   = t + upto;
    baddr = {7'b0, addr, 1'b0};
    k     = 1;
    hit   = 1'b0;
    if (BURST && in_hold) begin
      hit = (wr == last_wr) && (last_addr != 16'hFFFF) && (addr == last_addr + 16'd1);
      if (!hit) begin
        push_bus(lim, t + 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        k = 2;
      end
    end
    if (!hit) begin
      for (int i = 0; i < 2; i++)
        push_bus(lim, t + k + i, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, wr ? 8'h02 : 8'h03, 8'h00);
      for (int i = 0; i < 6; i++) begin
        nib = baddr[23 - 4*i -: 4];
        push_bus(lim, t + k + 2 + i, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, {nib, nib}, 8'h00);
      end
      k += 8;
      if (!wr) begin
        for (int i = 0; i < 2; i++)
          push_bus(lim, t + k + i, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        k += 2;
      end
    end
    push_bus(lim, t + k,     1'b0, 1'b1, wr, 1'b0, wr, data[7:0],  wr ? 8'h00 : rd[7:0]);
    push_bus(lim, t + k + 1, 1'b0, 1'b1, wr, 1'b0, wr, data[15:8], wr ? 8'h00 : rd[15:8]);
    k += 2;
    push_bus(lim, t + k, BURST ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    if (!wr && (t + k <= lim)) begin
      r.cyc  = t + k;
      r.data = rd;
      rq.push_back(r);
    end
    last_wr   = wr;
    last_addr = addr;
    in_hold   = BURST;
    @(negedge i_clk);
    i_req_vld = 1'b0;
  endtask

  // Monitor: compares scheduled pin states and plays the memories' read nibbles.
  initial begin
    exp_t e;
    rsp_t r;
    i_sqi_din = 8'h00;
    forever begin
      @(negedge i_clk);
      i_sqi_din = 8'h00;
      while (bq.size() > 0 && bq[0].cyc <= cyc) begin
        e = bq.pop_front();
        if (e.cyc < cyc) begin
          chk("bus_missed", 32'(e.cyc), 32'(cyc));
        end else begin
          chk("cs_n",    32'(o_sqi_cs_n),   32'(e.cs_n));
          chk("sck_en",  32'(o_sqi_sck_en), 32'(e.sck));
          chk("oe",      32'(o_sqi_oe),     32'(e.oe));
          chk("req_rdy", 32'(o_req_rdy),    32'(e.rdy));
          if (e.chk_dout) chk("dout", 32'(o_sqi_dout), 32'(e.dout));
          i_sqi_din = e.din;
        end
      end
      if (o_rsp_vld === 1'b1) begin
        if (rq.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          r = rq.pop_front();
          chk("rsp_cycle", 32'(cyc), 32'(r.cyc));
          chk("rsp_data",  32'(o_rsp_data), 32'(r.data));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    int n;
    i_rst_n    = 1'b0;
    i_req_vld  = 1'b0;
    i_req_wr   = 1'b0;
    i_req_addr = 16'h0000;
    i_req_data = 16'h0000;
    repeat (3) @(negedge i_clk);
    chk("rst_req_rdy",  32'(o_req_rdy),    32'd0);
    chk("rst_rsp_vld",  32'(o_rsp_vld),    32'd0);
    chk("rst_rsp_data", 32'(o_rsp_data),   32'd0);
    chk("rst_cs_n",     32'(o_sqi_cs_n),   32'd1);
    chk("rst_sck_en",   32'(o_sqi_sck_en), 32'd0);
    chk("rst_oe",       32'(o_sqi_oe),     32'd0);
    chk("rst_dout",     32'(o_sqi_dout),   32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    issue(1'b0, 16'h1234, 16'h0000, 16'hABCD, 99, t);
    issue(1'b1, 16'h0001, 16'hBEEF, 16'h0000, 99, t);

    // Reset while the address phase is on the pins; the read must vanish.
    issue(1'b0, 16'h0200, 16'h0000, 16'hFFFF, 5, t);
    n = 0;
    while (cyc < t + 5 && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    i_rst_n = 1'b0;
    push_bus(t + 99, t + 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    push_bus(t + 99, t + 7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    in_hold = 1'b0;
    repeat (20) @(negedge i_clk);

    issue(1'b0, 16'h0100, 16'h0000, 16'h3C5A, 99, t);
    issue(1'b1, 16'h0101, 16'h1357, 16'h0000, 99, t);
    issue(1'b0, 16'h0102, 16'h0000, 16'h2468, 99, t);

    issue(1'b0, 16'h0010, 16'h0000, 16'h2211, 99, t);
    repeat (6) @(negedge i_clk);
    issue(1'b0, 16'h0011, 16'h0000, 16'h3344, 99, t);
    issue(1'b0, 16'hFFFF, 16'h0000, 16'h5566, 99, t);
    issue(1'b0, 16'h0000, 16'h0000, 16'h7788, 99, t);

    n = 0;
    while ((bq.size() > 0 || rq.size() > 0) && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    chk("drain", 32'(bq.size() + rq.size()), 32'd0);
    repeat (4) @(negedge i_clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
